frame_scheduler: RTL

- Sequences per-frame game-logic tasks (paddle read, ball move, collision, score) during vertical blanking of the 640x480@72Hz timing generator.
- Detects the frame boundary as the vsync falling edge, then issues one-hot start pulses to up to N_TASKS requesters strictly in index order.
- Waits for each task's done handshake, bounded by a watchdog timeout.
- Reports frame count, update tick, overrun and timeout status to the top level.

---
 rtl/frame_sched_pkg.sv | 22 ++
 rtl/sched_watchdog.sv | 36 +++
 rtl/frame_scheduler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/frame_sched_pkg.sv
// Shared types and constants for the vblank task sequencer: FSM encoding,
// default timing parameters and the vertical-blanking cycle budget.
package frame_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } sched_state_t;

   localparam int unsigned DEF_TIMEOUT   = 32'd8192;
   localparam int unsigned DEF_FRAME_DIV = 32'd1;

   // 40 blanking lines of 832 pixel clocks each.
   localparam int unsigned VGA_BLANK_CYCLES = 32'd33280;

   function automatic logic budget_ok(input int unsigned timeout,
                                      input int unsigned n_tasks);
      return ((timeout * n_tasks) <= VGA_BLANK_CYCLES);
   endfunction

endpackage

// File: rtl/sched_watchdog.sv
// Loadable up-counter with synchronous clear and a terminal-count flag,
// shared by all tasks to bound the time spent waiting for one done.
module sched_watchdog #(
   parameter int unsigned WIDTH    = 32'd14,
   parameter int unsigned TERMINAL = 32'd8191
) (
   input  logic             px_clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             inc,
   output logic             tc
);

   localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(32'd1);
   localparam logic [WIDTH-1:0] CNT_TERM = WIDTH'(TERMINAL);

   logic [WIDTH-1:0] count_r;

   // Counter: clear has priority over load, load over increment.
   always_ff @(posedge px_clk or negedge reset_n) begin
      if (!reset_n) begin
         count_r <= '0;
      end else if (clr) begin
         count_r <= '0;
      end else if (load) begin
         count_r <= load_val;
      end else if (inc) begin
         count_r <= count_r + CNT_ONE;
      end
   end

   assign tc = (count_r == CNT_TERM);

endmodule

// File: rtl/frame_scheduler.sv
// Launches up to N_TASKS game-logic tasks in index order after each vsync
// falling edge, with a per-task done handshake bounded by a watchdog.
module frame_scheduler
   import frame_sched_pkg::*;
#(
   parameter int unsigned N_TASKS   = 32'd4,
   parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
   parameter int unsigned FRAME_DIV = DEF_FRAME_DIV,
   parameter int unsigned FRAME_W   = 32'd16
) (
   input  logic               px_clk,
   input  logic               reset_n,
   input  logic               vsync,
   input  logic               enable,
   input  logic               clear,
   input  logic [N_TASKS-1:0] task_done,
   output logic [N_TASKS-1:0] task_start,
   output logic               busy,
   output logic               tick,
   output logic [FRAME_W-1:0] frame_cnt,
   output logic               overrun,
   output logic [N_TASKS-1:0] timeout_flags
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT + 32'd1);
   localparam int unsigned DIV_W = (FRAME_DIV > 32'd1) ? $clog2(FRAME_DIV) : 32'd1;
   localparam int unsigned IDX_W = (N_TASKS > 32'd1) ? $clog2(N_TASKS) : 32'd1;

   localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(FRAME_DIV - 32'd1);
   localparam logic [DIV_W-1:0]   DIV_ONE   = DIV_W'(32'd1);
   localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(N_TASKS - 32'd1);
   localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(32'd1);
   localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(32'd1);
   localparam logic [N_TASKS-1:0] START_0   = N_TASKS'(32'd1);

   if ((N_TASKS < 32'd1) || (N_TASKS > 32'd8) || (TIMEOUT < 32'd2) ||
       (FRAME_DIV < 32'd1)) begin : g_bad_param
      $error("frame_scheduler: parameter out of range");
   end
   if (!budget_ok(TIMEOUT, N_TASKS)) begin : g_over_budget
      $error("frame_scheduler: TIMEOUT x N_TASKS exceeds the vblank budget");
   end

   sched_state_t      state_r;
   logic [IDX_W-1:0]  idx_r;
   logic [DIV_W-1:0]  div_cnt_r;
   logic              vs_r;
   logic              frame_evt_s;
   logic              due_s;
   logic              done_s;
   logic              timer_tc_s;

   assign frame_evt_s = vs_r & ~vsync;
   assign due_s       = (div_cnt_r == '0);
   assign done_s      = task_done[idx_r];

   sched_watchdog #(
      .WIDTH    (TMR_W),
      .TERMINAL (TIMEOUT - 32'd1)
   ) u_watchdog (
      .px_clk   (px_clk),
      .reset_n  (reset_n),
      .clr      (state_r == ST_ISSUE),
      .load     (1'b0),
      .load_val ({TMR_W{1'b0}}),
      .inc      (state_r == ST_WAIT),
      .tc       (timer_tc_s)
   );

   // Frame edge bookkeeping, task sequencing FSM and sticky status.
   always_ff @(posedge px_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r       <= ST_IDLE;
         idx_r         <= '0;
         div_cnt_r     <= '0;
         vs_r          <= 1'b1;
         task_start    <= '0;
         busy          <= 1'b0;
         tick          <= 1'b0;
         frame_cnt     <= '0;
         overrun       <= 1'b0;
         timeout_flags <= '0;
      end else begin
         vs_r       <= vsync;
         tick       <= 1'b0;
         task_start <= '0;

         if (frame_evt_s) begin
            frame_cnt <= frame_cnt + FRAME_ONE;
            div_cnt_r <= (div_cnt_r == DIV_LAST) ? '0 : (div_cnt_r + DIV_ONE);
         end

         // Clear first so that a set later in this block wins.
         if (clear) begin
            overrun       <= 1'b0;
            timeout_flags <= '0;
         end
         if (frame_evt_s && (state_r != ST_IDLE)) begin
            overrun <= 1'b1;
         end

         case (state_r)
            ST_IDLE: begin
               if (frame_evt_s && due_s && enable) begin
                  state_r    <= ST_ISSUE;
                  idx_r      <= '0;
                  task_start <= START_0;
                  tick       <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            ST_ISSUE: begin
               state_r <= ST_WAIT;
            end
            ST_WAIT: begin
               if (done_s || timer_tc_s) begin
                  if (!done_s) begin
                     timeout_flags[idx_r] <= 1'b1;
                  end
                  if (idx_r == IDX_LAST) begin
                     state_r <= ST_IDLE;
                     busy    <= 1'b0;
                  end else begin
                     state_r    <= ST_ISSUE;
                     idx_r      <= idx_r + IDX_ONE;
                     task_start <= START_0 << (idx_r + IDX_ONE);
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
